// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, widths and execute-sequencer state encoding
package cpu_pkg;

  localparam int DW = 8;
  localparam int AW = 5;

  // Opcode values double as the ALU selector encoding
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EXEC = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_HALT = 3'd5
  } state_t;

endpackage

// File: rtl/acc_flag_unit.sv
// rtl/acc_flag_unit.sv - next value of the E flag, derived locally since the ALU has no carry out
module acc_flag_unit
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW
) (
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] dr,
  input  logic [2:0]    op,
  input  logic          e_cur,
  output logic          e_next
);

  logic [DW:0] sum;

  assign sum = {1'b0, ac} + {1'b0, dr};

  always_comb begin
    e_next = e_cur;
    case (op)
      OP_ADD:  e_next = sum[DW];
      OP_SUB:  e_next = (ac >= dr);
      OP_SHL:  e_next = ac[DW-1];
      default: e_next = e_cur;
    endcase
  end

endmodule

// File: rtl/acc_exec_ctrl.sv
// rtl/acc_exec_ctrl.sv - accumulator execute sequencer: AC/DR/E, ALU operand drive, memory handshake
module acc_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_addr,
  output logic [DW-1:0] alu_ac,
  output logic [DW-1:0] alu_dr,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_result,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] ac,
  output logic          e,
  output logic          zero,
  output logic          done,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [DW-1:0] ac_q, dr_q;
  logic          e_q, e_next;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_q;

  acc_flag_unit #(.DW(DW)) u_flag (
    .ac     (ac_q),
    .dr     (dr_q),
    .op     (op_q),
    .e_cur  (e_q),
    .e_next (e_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    done        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (instr_op)
            OP_ADD, OP_SUB, OP_XOR, OP_LDA: state_d = S_RD;
            OP_SHL, OP_CMA:                 state_d = S_EXEC;
            OP_STA:                         state_d = S_WR;
            default:                        state_d = S_HALT;
          endcase
        end
      end
      S_RD: begin
        mem_rd = 1'b1;
        if (mem_ack) state_d = (op_q == OP_LDA) ? S_DONE : S_EXEC;
      end
      S_EXEC: state_d = S_DONE;
      S_WR: begin
        mem_wr = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q   <= '0;
      dr_q   <= '0;
      e_q    <= 1'b0;
      op_q   <= OP_ADD;
      addr_q <= '0;
    end else begin
      if (state_q == S_IDLE && instr_valid) begin
        op_q   <= instr_op;
        addr_q <= instr_addr;
      end
      if (state_q == S_RD && mem_ack) begin
        dr_q <= mem_rdata;
        if (op_q == OP_LDA) ac_q <= mem_rdata;
      end
      if (state_q == S_EXEC) begin
        ac_q <= alu_result;
        e_q  <= e_next;
      end
    end
  end

  assign alu_ac    = ac_q;
  assign alu_dr    = dr_q;
  assign alu_sel   = op_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = ac_q;
  assign ac        = ac_q;
  assign e         = e_q;
  assign zero      = (ac_q == '0);

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// tb/tb_acc_exec_ctrl.sv - directed self-checking bench for acc_exec_ctrl with ALU and memory models
module tb_acc_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [4:0] instr_addr;
  logic [7:0] alu_ac, alu_dr, alu_result;
  logic [2:0] alu_sel;
  logic       mem_rd, mem_wr, mem_ack;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] ac;
  logic       e, zero, done, halted;

  logic [7:0] mem [32];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  acc_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_addr  (instr_addr),
    .alu_ac      (alu_ac),
    .alu_dr      (alu_dr),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ac          (ac),
    .e           (e),
    .zero        (zero),
    .done        (done),
    .halted      (halted)
  );

  // Reference ALU sitting at the level above the sequencer
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_ac + alu_dr;
      3'b001:  alu_result = alu_ac - alu_dr;
      3'b010:  alu_result = alu_ac ^ alu_dr;
      3'b011:  alu_result = alu_ac << 1;
      3'b110:  alu_result = ~alu_ac;
      default: alu_result = alu_ac;
    endcase
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, serve its memory access after d wait cycles, check latency and done pulse
  task automatic issue(input logic [2:0] op, input logic [4:0] addr, input int d,
                       input logic [7:0] wexp, input int exp_lat);
    int lat;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_addr  = addr;
    chk("accept_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    lat = 1;
    if (op == 3'b000 || op == 3'b001 || op == 3'b010 || op == 3'b100) begin
      for (int i = 0; i < d; i++) begin
        chk("rd_wait", mem_rd, 1);
        chk("rd_addr", mem_addr, addr);
        tick();
        lat++;
      end
      mem_rdata = mem[addr];
      mem_ack   = 1'b1;
      chk("rd_ack", {mem_rd, mem_wr}, 2'b10);
      tick();
      lat++;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end else if (op == 3'b101) begin
      for (int i = 0; i <= d; i++) begin
        chk("wr_req", {mem_rd, mem_wr}, 2'b01);
        chk("wr_addr", mem_addr, addr);
        chk("wr_data", mem_wdata, wexp);
        if (i == d) begin
          mem_ack   = 1'b1;
          mem[addr] = mem_wdata;
        end
        tick();
        lat++;
      end
      mem_ack = 1'b0;
      chk("wr_release", mem_wr, 0);
    end
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    tick();
    chk("done_single", done, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'hFF; mem[1] = 8'h01; mem[2] = 8'h05; mem[3] = 8'h37;
    mem[4] = 8'h05; mem[5] = 8'h06; mem[6] = 8'h81; mem[8] = 8'h5E;
    mem[9] = 8'hFF;
    rst = 1'b1; instr_valid = 1'b0; instr_op = 3'b000; instr_addr = 5'd0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ac", ac, 8'h00);
    chk("rst_e", e, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ready", instr_ready, 1);
    chk("rst_ctrl", {mem_rd, mem_wr, done, halted}, 4'b0000);

    issue(3'b100, 5'd3, 2, 8'h00, 4);
    chk("lda3_ac", ac, 8'h37);
    issue(3'b000, 5'd4, 2, 8'h00, 5);
    chk("add_ac", ac, 8'h3C);
    chk("add_e", e, 0);

    issue(3'b100, 5'd0, 0, 8'h00, 2);
    issue(3'b000, 5'd1, 0, 8'h00, 3);
    chk("wrap_ac", ac, 8'h00);
    chk("wrap_e", e, 1);
    chk("wrap_zero", zero, 1);

    issue(3'b100, 5'd2, 0, 8'h00, 2);
    issue(3'b001, 5'd5, 1, 8'h00, 4);
    chk("sub_ac", ac, 8'hFF);
    chk("sub_e", e, 0);
    issue(3'b100, 5'd6, 0, 8'h00, 2);
    issue(3'b011, 5'd0, 0, 8'h00, 2);
    chk("shl_ac", ac, 8'h02);
    chk("shl_e", e, 1);
    issue(3'b110, 5'd0, 0, 8'h00, 2);
    chk("cma_ac", ac, 8'hFD);
    chk("cma_e", e, 1);

    issue(3'b100, 5'd8, 0, 8'h00, 2);
    issue(3'b101, 5'd7, 2, 8'h5E, 4);
    chk("sta_mem", mem[7], 8'h5E);
    chk("sta_ac", ac, 8'h5E);
    issue(3'b010, 5'd9, 0, 8'h00, 3);
    chk("xor_ac", ac, 8'hA1);
    chk("xor_e", e, 1);

    instr_valid = 1'b1; instr_op = 3'b100; instr_addr = 5'd3;
    tick();
    instr_valid = 1'b0;
    chk("rdwait_rd", mem_rd, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrd_rd", mem_rd, 0);
    chk("rstrd_ready", instr_ready, 1);
    mem_rdata = 8'h37; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("late_ack_ac", ac, 8'h00);
    chk("late_ack_dr", alu_dr, 8'h00);

    instr_valid = 1'b1; instr_op = 3'b111;
    tick();
    instr_op = 3'b100;
    chk("hlt_halted", halted, 1);
    chk("hlt_ready", instr_ready, 0);
    tick(); tick(); tick();
    chk("hlt_stay", {halted, instr_ready, mem_rd, mem_wr, done}, 5'b10000);
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hlt_rst", {halted, instr_ready}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
